// File: rtl/cic_decim_ctrl_pkg.sv
`default_nettype none
// ============================================================================
// Module : cic_decim_ctrl_pkg
// Brief  : Shared types and helpers for the CIC decimator sequencer.
//          Provides the sequencer state encoding and a floor-log2 helper
//          used to derive rate and counter widths.
// Rev    : 1.0  initial release
// ============================================================================
package cic_decim_ctrl_pkg;

    // Sequencer states: flush the CIC, discard the transient, then run.
    typedef enum logic [1:0] {
        ST_FLUSH  = 2'd0,
        ST_SETTLE = 2'd1,
        ST_RUN    = 2'd2
    } state_t;

    // Floor of log2; log2f(v)+1 bits always hold the value v.
    function automatic int log2f(input int value);
        int r;
        r = 0;
        for (int i = 0; i < 31; i++) begin
            if ((value >> i) != 0) begin
                r = i;
            end
        end
        return r;
    endfunction

endpackage : cic_decim_ctrl_pkg
`default_nettype wire

// File: rtl/cic_decim_ctrl_strobe_gen.sv
`default_nettype none
// ============================================================================
// Module : cic_decim_ctrl_strobe_gen
// Brief  : Decimation phase counter and CIC strobe generation.
//          act_o fires on every accepted sample; act_out_o fires on the
//          sample that completes a decimation period of rate_i samples.
// Ports  : clk_i, rst_n_i   clock, async active-low reset
//          en_i             global enable
//          in_valid_i       input sample present
//          active_i         sequencer allows strobes this cycle
//          clr_i            clear phase counter (rate load)
//          sync_i           phase-align request (0 when feature absent)
//          rate_i           active decimation rate
//          act_o            integrator strobe
//          act_out_o        decimation strobe
// Rev    : 1.0  initial release
// ============================================================================
module cic_decim_ctrl_strobe_gen #(
    parameter int RATE_W = 7
) (
    input  logic              clk_i,
    input  logic              rst_n_i,
    input  logic              en_i,
    input  logic              in_valid_i,
    input  logic              active_i,
    input  logic              clr_i,
    input  logic              sync_i,
    input  logic [RATE_W-1:0] rate_i,
    output logic              act_o,
    output logic              act_out_o
);

    logic [RATE_W-1:0] dcnt_q;
    logic [RATE_W-1:0] w_dcnt_eff;
    logic [RATE_W-1:0] w_last;
    logic              w_sync;
    logic              w_act;
    logic              w_wrap;

    assign w_sync     = sync_i & en_i & active_i;
    // A sync pulse makes the current sample (if any) sample 0 of a new period.
    assign w_dcnt_eff = w_sync ? '0 : dcnt_q;
    assign w_last     = rate_i - 1'b1;
    assign w_act      = active_i & en_i & in_valid_i;
    assign w_wrap     = (w_dcnt_eff == w_last);

    assign act_o      = w_act;
    assign act_out_o  = w_act & w_wrap;

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            dcnt_q <= '0;
        end else if (clr_i) begin
            dcnt_q <= '0;
        end else if (w_act) begin
            dcnt_q <= w_wrap ? '0 : (w_dcnt_eff + 1'b1);
        end else if (w_sync) begin
            dcnt_q <= '0;
        end
    end

endmodule : cic_decim_ctrl_strobe_gen
`default_nettype wire

// File: rtl/cic_decim_ctrl.sv
`default_nettype none
// ============================================================================
// Module : cic_decim_ctrl
// Brief  : CIC decimator sequencer. Generates integrator/decimation strobes
//          from the upstream sample strobe, owns the CIC reset, and after
//          every rate change flushes the filter and discards the transient
//          before flagging output data as valid.
// Config : CIC_CTRL_SYNC_EN  adds sync_i, a decimation phase-align pulse.
// Ports  : clk_i, rst_n_i   clock, async active-low reset
//          en_i             global enable (low freezes everything)
//          in_valid_i       input sample strobe
//          rate_i/rate_wr_i requested rate and its load strobe
//          sync_i           phase align (CIC_CTRL_SYNC_EN only)
//          cic_rst_o, cic_en_o, cic_act_o, cic_act_out_o  to the CIC
//          cic_val_i        CIC output valid
//          valid_o          settled CIC output valid
//          settled_o        sequencer in RUN
//          rate_o           active decimation rate
//          rate_err_o       one-cycle pulse on a rejected rate write
// Rev    : 1.0  initial release
// ============================================================================
module cic_decim_ctrl
    import cic_decim_ctrl_pkg::*;
#(
    parameter int MAXRATE      = 64,
    parameter int M            = 2,
    parameter int N            = 5,
    parameter int DEFAULT_RATE = MAXRATE,
    parameter int FLUSH_CYCLES = 2,
    parameter int SETTLE_OUTS  = N * (M + 1),
    localparam int RATE_W      = log2f(MAXRATE) + 1
) (
    input  logic              clk_i,
    input  logic              rst_n_i,
    input  logic              en_i,
    input  logic              in_valid_i,
    input  logic [RATE_W-1:0] rate_i,
    input  logic              rate_wr_i,
`ifdef CIC_CTRL_SYNC_EN
    input  logic              sync_i,
`endif
    output logic              cic_rst_o,
    output logic              cic_en_o,
    output logic              cic_act_o,
    output logic              cic_act_out_o,
    input  logic              cic_val_i,
    output logic              valid_o,
    output logic              settled_o,
    output logic [RATE_W-1:0] rate_o,
    output logic              rate_err_o
);

    localparam int FCNT_W = log2f(FLUSH_CYCLES) + 1;
    localparam int SCNT_W = log2f(SETTLE_OUTS) + 1;

    localparam logic [RATE_W-1:0] C_MAXRATE     = RATE_W'(MAXRATE);
    localparam logic [RATE_W-1:0] C_DEFAULT     = RATE_W'(DEFAULT_RATE);
    localparam logic [FCNT_W-1:0] C_FLUSH_LAST  = FCNT_W'(FLUSH_CYCLES - 1);
    localparam logic [SCNT_W-1:0] C_SETTLE_LAST = SCNT_W'(SETTLE_OUTS - 1);

    state_t            state_q;
    logic [FCNT_W-1:0] fcnt_q;
    logic [SCNT_W-1:0] scnt_q;
    logic [RATE_W-1:0] rate_q;
    logic              rate_err_q;

    logic              w_rate_ok;
    logic              w_wr_ok;
    logic              w_wr_bad;
    logic              w_active;
    logic              w_sync;

    assign w_rate_ok = (rate_i != '0) && (rate_i <= C_MAXRATE);
    assign w_wr_ok   = rate_wr_i & w_rate_ok;
    assign w_wr_bad  = rate_wr_i & ~w_rate_ok;
    // Strobes are suppressed in FLUSH and in the cycle a new rate is loaded.
    assign w_active  = (state_q != ST_FLUSH) & ~w_wr_ok;

`ifdef CIC_CTRL_SYNC_EN
    assign w_sync = sync_i;
`else
    assign w_sync = 1'b0;
`endif

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state_q    <= ST_FLUSH;
            fcnt_q     <= '0;
            scnt_q     <= '0;
            rate_q     <= C_DEFAULT;
            rate_err_q <= 1'b0;
        end else begin
            rate_err_q <= w_wr_bad;
            if (w_wr_ok) begin
                // Any accepted write (even of the current rate) restarts the flush.
                rate_q  <= rate_i;
                state_q <= ST_FLUSH;
                fcnt_q  <= '0;
                scnt_q  <= '0;
            end else if (en_i) begin
                case (state_q)
                    ST_FLUSH: begin
                        if (fcnt_q == C_FLUSH_LAST) begin
                            state_q <= ST_SETTLE;
                            fcnt_q  <= '0;
                        end else begin
                            fcnt_q <= fcnt_q + 1'b1;
                        end
                    end
                    ST_SETTLE: begin
                        if (cic_val_i) begin
                            if (scnt_q == C_SETTLE_LAST) begin
                                state_q <= ST_RUN;
                                scnt_q  <= '0;
                            end else begin
                                scnt_q <= scnt_q + 1'b1;
                            end
                        end
                    end
                    ST_RUN: begin
                        state_q <= ST_RUN;
                    end
                    default: begin
                        state_q <= ST_FLUSH;
                    end
                endcase
            end
        end
    end

    cic_decim_ctrl_strobe_gen #(
        .RATE_W (RATE_W)
    ) u_strobe_gen (
        .clk_i      (clk_i),
        .rst_n_i    (rst_n_i),
        .en_i       (en_i),
        .in_valid_i (in_valid_i),
        .active_i   (w_active),
        .clr_i      (w_wr_ok),
        .sync_i     (w_sync),
        .rate_i     (rate_q),
        .act_o      (cic_act_o),
        .act_out_o  (cic_act_out_o)
    );

    assign cic_rst_o  = (state_q == ST_FLUSH);
    assign cic_en_o   = en_i;
    assign settled_o  = (state_q == ST_RUN);
    assign valid_o    = (state_q == ST_RUN) & en_i & cic_val_i;
    assign rate_o     = rate_q;
    assign rate_err_o = rate_err_q;

endmodule : cic_decim_ctrl
`default_nettype wire

// File: tb/tb_cic_decim_ctrl.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module : tb_cic_decim_ctrl
// Brief  : Scoreboard bench for cic_decim_ctrl. A sample-index reference
//          model queues the expected per-cycle status and the cycles on
//          which decimation strobes and valid outputs must appear; a
//          monitor pops and compares as the DUT presents them. A one-cycle
//          register stands in for the CIC output valid.
// Rev    : 1.0  initial release
// ============================================================================
module tb_cic_decim_ctrl;

    localparam int MAXRATE      = 64;
    localparam int FLUSH_CYCLES = 2;
    localparam int SETTLE_OUTS  = 15;
    localparam int RATE_W       = 7;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic              en = 1'b0;
    logic              iv = 1'b0;
    logic              rate_wr = 1'b0;
    logic [RATE_W-1:0] rate_in = '0;
    logic              sync = 1'b0;
    logic              cic_val;
    logic              cic_rst_o, cic_en_o, cic_act_o, cic_act_out_o;
    logic              valid_o, settled_o, rate_err_o;
    logic [RATE_W-1:0] rate_o;

    always #5 clk = ~clk;

    cic_decim_ctrl dut (
        .clk_i         (clk),
        .rst_n_i       (rst_n),
        .en_i          (en),
        .in_valid_i    (iv),
        .rate_i        (rate_in),
        .rate_wr_i     (rate_wr),
`ifdef CIC_CTRL_SYNC_EN
        .sync_i        (sync),
`endif
        .cic_rst_o     (cic_rst_o),
        .cic_en_o      (cic_en_o),
        .cic_act_o     (cic_act_o),
        .cic_act_out_o (cic_act_out_o),
        .cic_val_i     (cic_val),
        .valid_o       (valid_o),
        .settled_o     (settled_o),
        .rate_o        (rate_o),
        .rate_err_o    (rate_err_o)
    );

    // Stand-in for the CIC: its output valid follows the decimation strobe by one cycle.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) cic_val <= 1'b0;
        else        cic_val <= cic_act_out_o;
    end

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int errors = 0;
    int checks = 0;

    task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h required %0h (cycle %0d)", name, got, exp, cyc);
        end
    endtask

    // ---------------- reference model ----------------
    typedef struct packed {
        logic [31:0] cyc;
        logic [11:0] v;   // {rst, settled, err, act, en, rate}
    } st_t;

    st_t q_st[$];
    int  q_ao[$];
    int  q_vo[$];
    bit  mon_on = 1'b0;

    int m_rate, m_mode, m_fl, m_sl, m_n;  // mode: 0 flush, 1 settle, 2 run
    bit m_pao, m_err;

    task automatic model_reset();
        m_rate = MAXRATE; m_mode = 0; m_fl = FLUSH_CYCLES; m_sl = SETTLE_OUTS;
        m_n = 0; m_pao = 1'b0; m_err = 1'b0;
    endtask

    task automatic cycle(input bit e, input bit v, input bit w, input int r, input bit s);
        bit ok, on, val, ea, eao, evo;
        st_t st;
        @(posedge clk); #1;
        en = e; iv = v; rate_wr = w; rate_in = RATE_W'(r); sync = s;
        ok  = w && (r >= 1) && (r <= MAXRATE);
        on  = (m_mode != 0) && e && !ok;
        val = m_pao;
`ifdef CIC_CTRL_SYNC_EN
        if (on && s) m_n = 0;
`endif
        ea  = on && v;
        eao = ea && ((m_n % m_rate) == m_rate - 1);
        evo = (m_mode == 2) && e && val;
        st.cyc = cyc;
        st.v   = {m_mode == 0, m_mode == 2, m_err, ea, e, RATE_W'(m_rate)};
        q_st.push_back(st);
        if (eao) q_ao.push_back(cyc);
        if (evo) q_vo.push_back(cyc);
        mon_on = 1'b1;
        m_err = w && !ok;
        m_pao = eao;
        if (ok) begin
            m_rate = r; m_mode = 0; m_fl = FLUSH_CYCLES; m_sl = SETTLE_OUTS; m_n = 0;
        end else if (e) begin
            if (ea) m_n++;
            case (m_mode)
                0: begin m_fl--; if (m_fl == 0) m_mode = 1; end
                1: if (val) begin m_sl--; if (m_sl == 0) m_mode = 2; end
                default: ;
            endcase
        end
    endtask

    // ---------------- monitor ----------------
    always @(negedge clk) begin
        if (mon_on) begin
            st_t st;
            if (q_st.size() == 0) begin
                checks++; errors++;
                $display("FAIL status_queue: got empty required an entry (cycle %0d)", cyc);
            end else begin
                st = q_st.pop_front();
                chk("status{rst,settled,err,act,en,rate}",
                    {cic_rst_o, settled_o, rate_err_o, cic_act_o, cic_en_o, rate_o}, st.v);
            end
            if (cic_act_out_o) begin
                if (q_ao.size() == 0) begin
                    checks++; errors++;
                    $display("FAIL act_out: got unexpected strobe required none (cycle %0d)", cyc);
                end else chk("act_out_cycle", cyc, q_ao.pop_front());
            end
            if (valid_o) begin
                if (q_vo.size() == 0) begin
                    checks++; errors++;
                    $display("FAIL valid_o: got unexpected valid required none (cycle %0d)", cyc);
                end else chk("valid_cycle", cyc, q_vo.pop_front());
            end
        end
    end

    task automatic check_drain();
        chk("act_out_drain", q_ao.size(), 0);
        chk("valid_drain", q_vo.size(), 0);
        q_ao.delete(); q_vo.delete(); q_st.delete();
    endtask

    task automatic do_reset();
        @(posedge clk); #1;
        mon_on = 1'b0;
        check_drain();
        en = 1'b0; iv = 1'b0; rate_wr = 1'b0; sync = 1'b0;
        rst_n = 1'b0; #1;
        chk("reset_outputs",
            {cic_rst_o, cic_en_o, cic_act_o, cic_act_out_o, valid_o, settled_o, rate_err_o, rate_o},
            {1'b1, 6'b0, RATE_W'(MAXRATE)});
        repeat (2) @(posedge clk);
        #1; rst_n = 1'b1;
        model_reset();
    endtask

    task automatic soak(input int n);
        for (int i = 0; i < n; i++) begin
            bit w, s;
            w = ($urandom_range(99, 0) == 0);
            s = 1'b0;
`ifdef CIC_CTRL_SYNC_EN
            s = ($urandom_range(19, 0) == 0);
`endif
            cycle($urandom_range(9, 0) != 0, $urandom_range(1, 0) == 1, w,
                  $urandom_range(70, 0), s);
        end
    endtask

    initial begin
        model_reset();
        do_reset();
        // Default rate 64, continuous samples: flush, settle on 15 outputs, run.
        repeat (1100) cycle(1, 1, 0, 0, 0);
        // Rate change to 4 from RUN.
        cycle(1, 1, 1, 4, 0);
        repeat (150) cycle(1, 1, 0, 0, 0);
        // Rejected writes: 0 and 65.
        cycle(1, 1, 1, 0, 0);
        cycle(1, 1, 1, 65, 0);
        repeat (5) cycle(1, 1, 0, 0, 0);
        // Write during flush restarts it; rate 8, sparse samples, enable gap.
        cycle(1, 1, 1, 5, 0);
        cycle(1, 1, 1, 8, 0);
        for (int i = 0; i < 500; i++) cycle(!(i >= 250 && i < 260), (i % 3) == 0, 0, 0, 0);
        // Rate 1: every sample decimates.
        cycle(1, 0, 1, 1, 0);
        for (int i = 0; i < 120; i++) cycle(1, $urandom_range(1, 0) == 1, 0, 0, 0);
        // Rate write honoured while disabled.
        cycle(0, 1, 1, 3, 0);
        for (int i = 0; i < 200; i++) cycle($urandom_range(9, 0) != 0, $urandom_range(1, 0) == 1, 0, 0, 0);
`ifdef CIC_CTRL_SYNC_EN
        // Rate 16, sync with a sample once the phase counter reaches 9.
        cycle(1, 0, 1, 16, 0);
        repeat (2) cycle(1, 0, 0, 0, 0);
        repeat (9) cycle(1, 1, 0, 0, 0);
        cycle(1, 1, 0, 0, 1);
        repeat (40) cycle(1, 1, 0, 0, 0);
        // Write and sync together: the write wins.
        cycle(1, 1, 1, 16, 1);
        repeat (30) cycle(1, 1, 0, 0, 0);
`endif
        soak(800);
        // Asynchronous reset mid-run, then resume at the default rate.
        cycle(1, 1, 1, 2, 0);
        repeat (20) cycle(1, 1, 0, 0, 0);
        do_reset();
        repeat (300) cycle(1, 1, 0, 0, 0);
        @(posedge clk); #1;
        mon_on = 1'b0;
        check_drain();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule : tb_cic_decim_ctrl
`default_nettype wire
